vga_sync_gen: RTL and testbench

//  Source end of the pixel-coordinate interface consumed by the graphics generators.

---
 rtl/vga_sync_gen.sv | 151 +++++++++++++++
 tb/tb_vga_sync_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing source for the graphics generators. A clock divider produces
//   a one-clk pixel tick, and horizontal/vertical counters walk the full raster
//   including porches and sync. The current position is published as
//   pix_x/pix_y together with video_on.
//
//   hsync, vsync and the colour from the graphics mux are registered together
//   on the pixel tick. This gives all three monitor-facing signals the same
//   one-pixel latency relative to pix_x/pix_y.
//
// Ports
//   clk         in   1   system clock, all state on rising edge
//   reset       in   1   asynchronous, active-low
//   rgb_in      in   12  colour for the current pix_x/pix_y
//   pix_x       out  10  horizontal position (0..H_TOTAL-1)
//   pix_y       out  10  vertical position   (0..V_TOTAL-1)
//   video_on    out  1   position lies inside the active area
//   p_tick      out  1   one-clk pixel strobe; counters advance on it
//   frame_tick  out  1   one-clk strobe as pix_y steps V_DISPLAY-1 -> V_DISPLAY
//   hsync       out  1   registered horizontal sync, SYNC_POL when asserted
//   vsync       out  1   registered vertical sync, SYNC_POL when asserted
//   rgb_out     out  12  registered colour, forced to zero while blanked
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        video_on,
  output logic        p_tick,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END   = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT_END   = 10'(V_DISPLAY);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_FIRST    = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST    = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Drive level of a sync line for a given "inside sync window" flag.
  function automatic logic sync_level(input logic act);
    return act ? SYNC_POL : ~SYNC_POL;
  endfunction

  // Colour passed to the DAC: the generator's colour only inside the active area.
  function automatic logic [11:0] blank_rgb(input logic on, input logic [11:0] rgb);
    return on ? rgb : 12'h000;
  endfunction

  logic [9:0]  h_p0;
  logic [9:0]  v_p0;
  logic        hs_act_p0;
  logic        vs_act_p0;
  logic        hsync_p1;
  logic        vsync_p1;
  logic [11:0] rgb_p1;

  // ---- stage 0: pixel-rate divider ----
  generate
    if (CLK_DIV <= 1) begin : g_no_div
      // Pixel rate equals clock rate: every edge is a pixel edge.
      assign p_tick = 1'b1;
    end else begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_p0;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          div_p0 <= '0;
        end else if (div_p0 == DIV_LAST) begin
          div_p0 <= '0;
        end else begin
          div_p0 <= div_p0 + 1'b1;
        end
      end

      assign p_tick = (div_p0 == DIV_LAST);
    end
  endgenerate

  // ---- stage 0: raster counters ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_p0 <= '0;
      v_p0 <= '0;
    end else if (p_tick) begin
      if (h_p0 == H_LAST) begin
        h_p0 <= '0;
        if (v_p0 == V_LAST) begin
          v_p0 <= '0;
        end else begin
          v_p0 <= v_p0 + 1'b1;
        end
      end else begin
        h_p0 <= h_p0 + 1'b1;
      end
    end
  end

  assign pix_x      = h_p0;
  assign pix_y      = v_p0;
  assign video_on   = (h_p0 < H_ACT_END) && (v_p0 < V_ACT_END);
  assign frame_tick = p_tick && (h_p0 == H_LAST) && (v_p0 == V_ACT_LAST);
  assign hs_act_p0  = (h_p0 >= HS_FIRST) && (h_p0 <= HS_LAST);
  assign vs_act_p0  = (v_p0 >= VS_FIRST) && (v_p0 <= VS_LAST);

  // ---- stage 1: monitor output register, advanced only on pixel edges ----
  // Reset forces the sync lines inactive at once so an interrupted frame never
  // leaves a stretched sync pulse on the cable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_p1 <= sync_level(1'b0);
      vsync_p1 <= sync_level(1'b0);
      rgb_p1   <= 12'h000;
    end else if (p_tick) begin
      hsync_p1 <= sync_level(hs_act_p0);
      vsync_p1 <= sync_level(vs_act_p0);
      rgb_p1   <= blank_rgb(video_on, rgb_in);
    end
  end

  assign hsync   = hsync_p1;
  assign vsync   = vsync_p1;
  assign rgb_out = rgb_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: default 640x480 timing, CLK_DIV=4, active-low syncs.
  logic        reset_a;
  logic [11:0] rgb_in_a;
  logic [9:0]  pix_x_a, pix_y_a;
  logic        video_on_a, p_tick_a, frame_tick_a, hsync_a, vsync_a;
  logic [11:0] rgb_out_a;

  // DUT b: tiny raster (16 x 13), CLK_DIV=1, active-high syncs.
  logic        reset_b;
  logic [11:0] rgb_in_b;
  logic [9:0]  pix_x_b, pix_y_b;
  logic        video_on_b, p_tick_b, frame_tick_b, hsync_b, vsync_b;
  logic [11:0] rgb_out_b;

  int n_vec = 0;
  int n_err = 0;

  vga_sync_gen #(
    .CLK_DIV(4), .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_DISPLAY(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset_a), .rgb_in(rgb_in_a),
    .pix_x(pix_x_a), .pix_y(pix_y_a), .video_on(video_on_a), .p_tick(p_tick_a),
    .frame_tick(frame_tick_a), .hsync(hsync_a), .vsync(vsync_a), .rgb_out(rgb_out_a)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset_b), .rgb_in(rgb_in_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .video_on(video_on_b), .p_tick(p_tick_b),
    .frame_tick(frame_tick_b), .hsync(hsync_b), .vsync(vsync_b), .rgb_out(rgb_out_b)
  );

  // Pulse reset on DUT a between edges; the next negedge is sample k=1.
  task automatic restart_a();
    @(negedge clk);
    reset_a = 1'b0;
    #2;
    reset_a = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (pix_x_a !== 10'd0)   begin $display("FAIL rst_pix_x: got %0d want 0", pix_x_a); n_err++; end
    n_vec++; if (pix_y_a !== 10'd0)   begin $display("FAIL rst_pix_y: got %0d want 0", pix_y_a); n_err++; end
    n_vec++; if (video_on_a !== 1'b1) begin $display("FAIL rst_video_on: got %b want 1", video_on_a); n_err++; end
    n_vec++; if (p_tick_a !== 1'b0)   begin $display("FAIL rst_p_tick: got %b want 0", p_tick_a); n_err++; end
    n_vec++; if (frame_tick_a !== 1'b0) begin $display("FAIL rst_frame_tick: got %b want 0", frame_tick_a); n_err++; end
    n_vec++; if (hsync_a !== 1'b1)    begin $display("FAIL rst_hsync: got %b want 1", hsync_a); n_err++; end
    n_vec++; if (vsync_a !== 1'b1)    begin $display("FAIL rst_vsync: got %b want 1", vsync_a); n_err++; end
    n_vec++; if (rgb_out_a !== 12'h0) begin $display("FAIL rst_rgb: got %h want 000", rgb_out_a); n_err++; end
    n_vec++; if (p_tick_b !== 1'b1)   begin $display("FAIL rst_p_tick_div1: got %b want 1", p_tick_b); n_err++; end
    n_vec++; if (hsync_b !== 1'b0)    begin $display("FAIL rst_hsync_pol1: got %b want 0", hsync_b); n_err++; end
    n_vec++; if (vsync_b !== 1'b0)    begin $display("FAIL rst_vsync_pol1: got %b want 0", vsync_b); n_err++; end
    n_vec++; if (pix_x_b !== 10'd0)   begin $display("FAIL rst_pix_x_div1: got %0d want 0", pix_x_b); n_err++; end
    // Held in reset across clock edges: nothing moves.
    repeat (3) @(negedge clk);
    n_vec++; if (pix_x_a !== 10'd0)   begin $display("FAIL rst_hold_pix_x: got %0d want 0", pix_x_a); n_err++; end
    // Release between edges, then walk the first eight edges.
    reset_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (p_tick_a !== ((k == 3 || k == 7) ? 1'b1 : 1'b0)) begin
        $display("FAIL rel_p_tick k=%0d: got %b want %b", k, p_tick_a, (k == 3 || k == 7)); n_err++;
      end
      n_vec++;
      if (pix_x_a !== ((k < 4) ? 10'd0 : (k < 8) ? 10'd1 : 10'd2)) begin
        $display("FAIL rel_pix_x k=%0d: got %0d", k, pix_x_a); n_err++;
      end
      if (k <= 3) begin
        n_vec++;
        if (hsync_a !== 1'b1 || vsync_a !== 1'b1 || rgb_out_a !== 12'h0) begin
          $display("FAIL rel_outputs k=%0d: got hs=%b vs=%b rgb=%h want 1 1 000", k, hsync_a, vsync_a, rgb_out_a); n_err++;
        end
      end
    end
  endtask

  task automatic test_line();
    int hs_low, first_low_x, bad, prev_x, prev_tick, wrap_k, y_after;
    hs_low = 0; first_low_x = -1; bad = 0; prev_x = 0; prev_tick = 0; wrap_k = -1; y_after = -1;
    rgb_in_a = 12'h000;
    restart_a();
    for (int k = 1; k <= 3300; k++) begin
      @(negedge clk);
      if (hsync_a === 1'b0) begin
        hs_low++;
        if (first_low_x < 0) first_low_x = int'(pix_x_a);
      end
      if (int'(pix_x_a) != prev_x) begin
        if (prev_tick == 0 || int'(pix_x_a) != ((prev_x == 799) ? 0 : prev_x + 1)) bad++;
      end else if (prev_tick != 0) begin
        bad++;
      end
      if (prev_x == 799 && pix_x_a == 10'd0 && wrap_k < 0) begin
        wrap_k = k; y_after = int'(pix_y_a);
      end
      prev_x = int'(pix_x_a);
      prev_tick = int'(p_tick_a);
    end
    n_vec++; if (bad !== 0)           begin $display("FAIL line_step: got %0d bad steps want 0", bad); n_err++; end
    n_vec++; if (wrap_k !== 3200)     begin $display("FAIL line_wrap_clk: got %0d want 3200", wrap_k); n_err++; end
    n_vec++; if (y_after !== 1)       begin $display("FAIL line_pix_y_inc: got %0d want 1", y_after); n_err++; end
    n_vec++; if (hs_low !== 384)      begin $display("FAIL hsync_width: got %0d clks want 384", hs_low); n_err++; end
    n_vec++; if (first_low_x !== 657) begin $display("FAIL hsync_start: got pix_x %0d want 657", first_low_x); n_err++; end
    n_vec++; if (vsync_a !== 1'b1)    begin $display("FAIL line_vsync: got %b want 1", vsync_a); n_err++; end
  endtask

  task automatic test_rgb();
    int cnt;
    cnt = 0;
    rgb_in_a = 12'hABC;
    restart_a();
    for (int k = 1; k <= 3200; k++) begin
      @(negedge clk);
      if (rgb_out_a === 12'hABC) cnt++;
      if (k == 3) begin
        n_vec++; if (rgb_out_a !== 12'h000) begin $display("FAIL rgb_before_first: got %h want 000", rgb_out_a); n_err++; end
      end
      if (k == 4) begin
        n_vec++; if (rgb_out_a !== 12'hABC) begin $display("FAIL rgb_first: got %h want abc", rgb_out_a); n_err++; end
      end
      if (k == 2563) begin
        n_vec++; if (pix_x_a !== 10'd640 || rgb_out_a !== 12'hABC) begin
          $display("FAIL rgb_last_active: got x=%0d rgb=%h want 640 abc", pix_x_a, rgb_out_a); n_err++; end
      end
      if (k == 2564) begin
        n_vec++; if (pix_x_a !== 10'd641 || rgb_out_a !== 12'h000) begin
          $display("FAIL rgb_blank: got x=%0d rgb=%h want 641 000", pix_x_a, rgb_out_a); n_err++; end
      end
      if (k == 3200) begin
        n_vec++; if (pix_x_a !== 10'd0 || pix_y_a !== 10'd1 || rgb_out_a !== 12'h000) begin
          $display("FAIL rgb_line1_x0: got x=%0d y=%0d rgb=%h want 0 1 000", pix_x_a, pix_y_a, rgb_out_a); n_err++; end
      end
    end
    n_vec++; if (cnt !== 2560) begin $display("FAIL rgb_active_clks: got %0d want 2560", cnt); n_err++; end
    // rgb_in must only be sampled on pixel edges.
    repeat (4) @(negedge clk);
    n_vec++; if (rgb_out_a !== 12'hABC) begin $display("FAIL rgb_line1_x1: got %h want abc", rgb_out_a); n_err++; end
    rgb_in_a = 12'h555;
    repeat (3) @(negedge clk);
    n_vec++; if (rgb_out_a !== 12'hABC || p_tick_a !== 1'b1) begin
      $display("FAIL rgb_hold: got rgb=%h tick=%b want abc 1", rgb_out_a, p_tick_a); n_err++; end
    @(negedge clk);
    n_vec++; if (rgb_out_a !== 12'h555) begin $display("FAIL rgb_sample: got %h want 555", rgb_out_a); n_err++; end
    rgb_in_a = 12'hABC;
  endtask

  task automatic test_midreset();
    int found;
    for (int pass = 0; pass < 2; pass++) begin
      restart_a();
      found = 0;
      for (int k = 1; k <= 4000 && found == 0; k++) begin
        @(negedge clk);
        if (pix_y_a == 10'd0 && pix_x_a == ((pass == 0) ? 10'd300 : 10'd700)) found = 1;
      end
      n_vec++;
      if (found == 0) begin
        $display("FAIL midreset_timeout pass=%0d: got x=%0d want target reached", pass, pix_x_a); n_err++;
      end else begin
        if (pass == 0) begin
          if (rgb_out_a !== 12'hABC) begin $display("FAIL midreset_pre_rgb: got %h want abc", rgb_out_a); n_err++; end
        end else begin
          if (hsync_a !== 1'b0) begin $display("FAIL midreset_pre_hsync: got %b want 0", hsync_a); n_err++; end
        end
        reset_a = 1'b0;
        #1;
        n_vec++; if (pix_x_a !== 10'd0 || pix_y_a !== 10'd0) begin
          $display("FAIL midreset_pix: got %0d,%0d want 0,0", pix_x_a, pix_y_a); n_err++; end
        n_vec++; if (hsync_a !== 1'b1 || vsync_a !== 1'b1) begin
          $display("FAIL midreset_sync: got hs=%b vs=%b want 1 1", hsync_a, vsync_a); n_err++; end
        n_vec++; if (rgb_out_a !== 12'h000) begin $display("FAIL midreset_rgb: got %h want 000", rgb_out_a); n_err++; end
        #1;
        reset_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
          @(negedge clk);
          n_vec++;
          if (p_tick_a !== ((k == 3) ? 1'b1 : 1'b0) || pix_x_a !== ((k == 4) ? 10'd1 : 10'd0)) begin
            $display("FAIL midreset_restart k=%0d: got tick=%b x=%0d", k, p_tick_a, pix_x_a); n_err++;
          end
        end
      end
    end
  endtask

  task automatic test_clkdiv1();
    int ft_cnt, ft_first, ft_second, hs_hi, vs_hi, rgb_nz, tick_bad;
    ft_cnt = 0; ft_first = -1; ft_second = -1; hs_hi = 0; vs_hi = 0; rgb_nz = 0; tick_bad = 0;
    rgb_in_b = 12'h5A5;
    @(negedge clk);
    reset_b = 1'b1;
    for (int k = 1; k <= 416; k++) begin
      @(negedge clk);
      if (p_tick_b !== 1'b1) tick_bad++;
      if (frame_tick_b === 1'b1) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = k; else if (ft_second < 0) ft_second = k;
      end
      if (hsync_b === 1'b1) hs_hi++;
      if (vsync_b === 1'b1) vs_hi++;
      if (rgb_out_b !== 12'h000) rgb_nz++;
      if (k == 1) begin
        n_vec++; if (pix_x_b !== 10'd1) begin $display("FAIL div1_first: got %0d want 1", pix_x_b); n_err++; end
      end
      if (k == 7 || k == 8) begin
        n_vec++; if (video_on_b !== ((k == 7) ? 1'b1 : 1'b0)) begin
          $display("FAIL div1_video_on k=%0d: got %b", k, video_on_b); n_err++; end
      end
      if (k == 16) begin
        n_vec++; if (pix_x_b !== 10'd0 || pix_y_b !== 10'd1) begin
          $display("FAIL div1_line: got %0d,%0d want 0,1", pix_x_b, pix_y_b); n_err++; end
      end
      if (k == 95) begin
        n_vec++; if (frame_tick_b !== 1'b1 || pix_x_b !== 10'd15 || pix_y_b !== 10'd5) begin
          $display("FAIL div1_frame_tick: got ft=%b at %0d,%0d want 1 at 15,5", frame_tick_b, pix_x_b, pix_y_b); n_err++; end
      end
      if (k == 96) begin
        n_vec++; if (pix_y_b !== 10'd6 || video_on_b !== 1'b0) begin
          $display("FAIL div1_after_ft: got y=%0d von=%b want 6 0", pix_y_b, video_on_b); n_err++; end
      end
      if (k == 208) begin
        n_vec++; if (pix_x_b !== 10'd0 || pix_y_b !== 10'd0) begin
          $display("FAIL div1_frame_wrap: got %0d,%0d want 0,0", pix_x_b, pix_y_b); n_err++; end
      end
    end
    n_vec++; if (tick_bad !== 0) begin $display("FAIL div1_tick_const: got %0d low want 0", tick_bad); n_err++; end
    n_vec++; if (ft_cnt !== 2)   begin $display("FAIL div1_ft_count: got %0d want 2", ft_cnt); n_err++; end
    n_vec++; if (ft_second - ft_first !== 208) begin
      $display("FAIL div1_ft_period: got %0d want 208", ft_second - ft_first); n_err++; end
    n_vec++; if (hs_hi !== 78)   begin $display("FAIL div1_hsync_count: got %0d want 78", hs_hi); n_err++; end
    n_vec++; if (vs_hi !== 64)   begin $display("FAIL div1_vsync_count: got %0d want 64", vs_hi); n_err++; end
    n_vec++; if (rgb_nz !== 96)  begin $display("FAIL div1_rgb_count: got %0d want 96", rgb_nz); n_err++; end
    // Advance to h=12, v=8: both sync pulses active, then reset mid-pulse.
    repeat (140) @(negedge clk);
    n_vec++; if (pix_x_b !== 10'd12 || pix_y_b !== 10'd8 || hsync_b !== 1'b1 || vsync_b !== 1'b1) begin
      $display("FAIL div1_pre_reset: got %0d,%0d hs=%b vs=%b want 12,8 1 1", pix_x_b, pix_y_b, hsync_b, vsync_b); n_err++; end
    reset_b = 1'b0;
    #1;
    n_vec++; if (hsync_b !== 1'b0 || vsync_b !== 1'b0 || pix_x_b !== 10'd0 || pix_y_b !== 10'd0 || rgb_out_b !== 12'h0) begin
      $display("FAIL div1_midreset: got hs=%b vs=%b pos=%0d,%0d rgb=%h want 0 0 0,0 000",
               hsync_b, vsync_b, pix_x_b, pix_y_b, rgb_out_b); n_err++; end
    #1;
    reset_b = 1'b1;
    @(negedge clk);
    n_vec++; if (pix_x_b !== 10'd1) begin $display("FAIL div1_restart: got %0d want 1", pix_x_b); n_err++; end
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    rgb_in_a = 12'h000; rgb_in_b = 12'h000;
    #2;
    reset_a = 1'b0; reset_b = 1'b0;
    test_reset();
    test_line();
    test_rgb();
    test_midreset();
    test_clkdiv1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
